// File: rtl/hv_wdg_scan_mc_if.sv
// Read channel between the watchdog scanner and the register-access controller.
interface hv_wdg_scan_mc_if #(
   parameter int REG_AW    = 7,
   parameter int REG_DW    = 8,
   parameter int REG_CRC_W = 8
);
   logic                 rd_req;
   logic [REG_AW-1:0]    rd_addr;
   logic                 rd_ack;
   logic [REG_DW-1:0]    rd_data;
   logic [REG_CRC_W-1:0] rd_crc;

   modport master (output rd_req, rd_addr, input rd_ack, rd_data, rd_crc);
   modport slave  (input rd_req, rd_addr, output rd_ack, rd_data, rd_crc);
endinterface

// File: rtl/hv_wdg_scan_mc.sv
// HV watchdog: periodic CRC-checked register scan with retries, failure threshold,
// BIST-triggered single reads and independent one-wire transfer timeout monitors.
module hv_wdg_tmo_ch #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             kick,
   input  logic [CNT_W-1:0] th,
   output logic             err
);
   logic [CNT_W-1:0] cnt, lim;

   assign lim = (th == '0) ? '0 : th - 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (!en || kick)     cnt <= '0;
         else if (cnt < lim)  cnt <= cnt + 1'b1;
         // err is sticky across disable; only a kick releases it
         if (kick)                   err <= 1'b0;
         else if (en && cnt >= lim)  err <= 1'b1;
      end
   end
endmodule

module hv_wdg_scan_mc #(
   parameter int REG_AW    = 7,
   parameter int REG_DW    = 8,
   parameter int REG_CRC_W = 8,
   parameter int SCAN_NUM  = 17,
   parameter int CNT_W     = 16,
   parameter int ACK_TMO   = 15,
   parameter int RETRY_MAX = 2,
   parameter int TMO_CH    = 2,
   parameter int FAIL_W    = 3
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_scan_en,
   input  logic [CNT_W-1:0]             i_scan_intv,
   input  logic [SCAN_NUM*REG_AW-1:0]   i_scan_addr_tbl,
   input  logic [FAIL_W-1:0]            i_fail_th,
   hv_wdg_scan_mc_if.master             rac,
   output logic                         o_crc_err,
   output logic                         o_scan_fault,
   input  logic                         i_fault_clr,
   output logic [$clog2(SCAN_NUM)-1:0]  o_scan_ptr,
   input  logic                         i_bist_req,
   output logic                         o_bist_ack,
   output logic                         o_bist_err,
   input  logic [TMO_CH-1:0]            i_tmo_en,
   input  logic [TMO_CH-1:0]            i_tmo_kick,
   input  logic [TMO_CH*CNT_W-1:0]      i_tmo_th,
   output logic [TMO_CH-1:0]            o_tmo_err
);
   localparam int PTR_W = $clog2(SCAN_NUM);
   localparam int RTY_W = $clog2(RETRY_MAX + 2);
   localparam logic [CNT_W-1:0]     ACK_LIM  = CNT_W'(ACK_TMO - 1);
   localparam logic [REG_CRC_W-1:0] CRC_POLY = REG_CRC_W'(8'h07);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_CHK, S_RETRY} state_t;

   // MSB-first CRC, poly x^8+x^2+x+1, zero init, over {1'b1, addr, data}
   function automatic logic [REG_CRC_W-1:0] crc16to8_parallel(input logic [REG_AW+REG_DW:0] d);
      logic [REG_CRC_W-1:0] c;
      c = '0;
      for (int i = REG_AW + REG_DW; i >= 0; i--)
         c = {c[REG_CRC_W-2:0], 1'b0} ^ ((c[REG_CRC_W-1] ^ d[i]) ? CRC_POLY : '0);
      return c;
   endfunction

   state_t              state, state_nx;
   logic [CNT_W-1:0]    intv_cnt, intv_cnt_nx, ack_cnt, ack_cnt_nx, intv_lim;
   logic [RTY_W-1:0]    retry_cnt, retry_nx;
   logic [FAIL_W-1:0]   fail_cnt, fail_nx;
   logic [PTR_W-1:0]    ptr, ptr_nx, ptr_inc;
   logic [REG_AW-1:0]   addr_nx, tbl_addr;
   logic                req_nx, att_fail, att_fail_nx;
   logic                bist_act, bist_act_nx, bist_pend, pend_nx, bist_q, bist_rise;
   logic                crc_err_nx, bist_ack_nx, bist_err_nx, fault_nx;

   assign intv_lim   = (i_scan_intv == '0) ? '0 : i_scan_intv - 1'b1;
   assign tbl_addr   = i_scan_addr_tbl[32'(ptr)*REG_AW +: REG_AW];
   assign ptr_inc    = (ptr == PTR_W'(SCAN_NUM - 1)) ? '0 : ptr + 1'b1;
   assign bist_rise  = i_bist_req & ~bist_q;
   assign o_scan_ptr = ptr;

   always_comb begin
      state_nx    = state;
      intv_cnt_nx = intv_cnt;
      ack_cnt_nx  = ack_cnt;
      retry_nx    = retry_cnt;
      fail_nx     = fail_cnt;
      ptr_nx      = ptr;
      req_nx      = rac.rd_req;
      addr_nx     = rac.rd_addr;
      att_fail_nx = att_fail;
      bist_act_nx = bist_act;
      pend_nx     = bist_pend;
      crc_err_nx  = 1'b0;
      bist_ack_nx = 1'b0;
      bist_err_nx = 1'b0;
      case (state)
         S_IDLE, S_WAIT: begin
            if (bist_rise || bist_pend) begin
               req_nx      = 1'b1;
               addr_nx     = tbl_addr;
               intv_cnt_nx = '0;
               bist_act_nx = 1'b1;
               pend_nx     = 1'b0;
               state_nx    = S_REQ;
            end else if (!i_scan_en) begin
               intv_cnt_nx = '0;
               state_nx    = S_IDLE;
            end else if (state == S_IDLE) begin
               state_nx = S_WAIT;
            end else if (intv_cnt >= intv_lim) begin
               req_nx      = 1'b1;
               addr_nx     = tbl_addr;
               intv_cnt_nx = '0;
               state_nx    = S_REQ;
            end else begin
               intv_cnt_nx = intv_cnt + 1'b1;
            end
         end
         S_REQ: begin
            if (bist_rise) pend_nx = 1'b1;
            if (rac.rd_ack) begin
               req_nx      = 1'b0;
               ack_cnt_nx  = '0;
               att_fail_nx = (rac.rd_crc != crc16to8_parallel({1'b1, rac.rd_addr, rac.rd_data}));
               state_nx    = S_CHK;
            end else if (ack_cnt >= ACK_LIM) begin
               req_nx      = 1'b0;
               ack_cnt_nx  = '0;
               att_fail_nx = 1'b1;
               state_nx    = S_CHK;
            end else begin
               ack_cnt_nx = ack_cnt + 1'b1;
            end
         end
         S_CHK: begin
            if (bist_rise) pend_nx = 1'b1;
            if (att_fail && retry_cnt < RTY_W'(RETRY_MAX)) begin
               crc_err_nx = 1'b1;
               retry_nx   = retry_cnt + 1'b1;
               state_nx   = S_RETRY;
            end else begin
               // entry done: pass clears the run of failures, final fail extends it
               crc_err_nx = att_fail;
               fail_nx    = !att_fail ? '0 : (fail_cnt == '1) ? fail_cnt : fail_cnt + 1'b1;
               retry_nx   = '0;
               ptr_nx     = ptr_inc;
               if (bist_act) begin
                  bist_ack_nx = 1'b1;
                  bist_err_nx = att_fail;
                  bist_act_nx = 1'b0;
               end
               state_nx = i_scan_en ? S_WAIT : S_IDLE;
            end
         end
         S_RETRY: begin
            if (bist_rise) pend_nx = 1'b1;
            req_nx   = 1'b1;
            state_nx = S_REQ;
         end
         default: state_nx = S_IDLE;
      endcase
      if (i_fault_clr) fail_nx = '0;
      fault_nx = i_fault_clr ? 1'b0
               : (o_scan_fault | ((i_fail_th != '0) && (fail_cnt >= i_fail_th)));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         intv_cnt     <= '0;
         ack_cnt      <= '0;
         retry_cnt    <= '0;
         fail_cnt     <= '0;
         ptr          <= '0;
         rac.rd_req   <= 1'b0;
         rac.rd_addr  <= '0;
         att_fail     <= 1'b0;
         bist_act     <= 1'b0;
         bist_pend    <= 1'b0;
         bist_q       <= 1'b0;
         o_crc_err    <= 1'b0;
         o_bist_ack   <= 1'b0;
         o_bist_err   <= 1'b0;
         o_scan_fault <= 1'b0;
      end else begin
         state        <= state_nx;
         intv_cnt     <= intv_cnt_nx;
         ack_cnt      <= ack_cnt_nx;
         retry_cnt    <= retry_nx;
         fail_cnt     <= fail_nx;
         ptr          <= ptr_nx;
         rac.rd_req   <= req_nx;
         rac.rd_addr  <= addr_nx;
         att_fail     <= att_fail_nx;
         bist_act     <= bist_act_nx;
         bist_pend    <= pend_nx;
         bist_q       <= i_bist_req;
         o_crc_err    <= crc_err_nx;
         o_bist_ack   <= bist_ack_nx;
         o_bist_err   <= bist_err_nx;
         o_scan_fault <= fault_nx;
      end
   end

   for (genvar c = 0; c < TMO_CH; c++) begin : g_tmo
      hv_wdg_tmo_ch #(.CNT_W(CNT_W)) u_ch (
         .clk   (i_clk),
         .rst_n (i_rst_n),
         .en    (i_tmo_en[c]),
         .kick  (i_tmo_kick[c]),
         .th    (i_tmo_th[c*CNT_W +: CNT_W]),
         .err   (o_tmo_err[c])
      );
   end
endmodule

// File: tb/tb_hv_wdg_scan_mc.sv
// Randomized bench: a rac responder with selectable fault policy plus a
// transaction-level scoreboard of reads, retries, failures, BIST and timeouts.
module tb_hv_wdg_scan_mc;
   localparam int AW = 7, DW = 8, CRW = 8, N = 17, CW = 16;
   localparam int ACK_TMO = 15, RETRY_MAX = 2, TMO_CH = 2, FW = 3;
   localparam int PW = $clog2(N);

   logic               clk = 1'b0, rst_n = 1'b0;
   logic               scan_en = 1'b0, fault_clr = 1'b0, bist_req = 1'b0;
   logic [CW-1:0]      scan_intv = '0;
   logic [N*AW-1:0]    tbl_v;
   logic [FW-1:0]      fail_th = '0;
   logic               crc_err, scan_fault, bist_ack, bist_err;
   logic [PW-1:0]      scan_ptr;
   logic [TMO_CH-1:0]  tmo_en = '0, tmo_kick = '0, tmo_err;
   logic [TMO_CH*CW-1:0] tmo_th = '0;

   always #5 clk = ~clk;

   hv_wdg_scan_mc_if #(.REG_AW(AW), .REG_DW(DW), .REG_CRC_W(CRW)) rac();

   hv_wdg_scan_mc #(.REG_AW(AW), .REG_DW(DW), .REG_CRC_W(CRW), .SCAN_NUM(N), .CNT_W(CW),
      .ACK_TMO(ACK_TMO), .RETRY_MAX(RETRY_MAX), .TMO_CH(TMO_CH), .FAIL_W(FW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_scan_en(scan_en), .i_scan_intv(scan_intv),
      .i_scan_addr_tbl(tbl_v), .i_fail_th(fail_th), .rac(rac), .o_crc_err(crc_err),
      .o_scan_fault(scan_fault), .i_fault_clr(fault_clr), .o_scan_ptr(scan_ptr),
      .i_bist_req(bist_req), .o_bist_ack(bist_ack), .o_bist_err(bist_err),
      .i_tmo_en(tmo_en), .i_tmo_kick(tmo_kick), .i_tmo_th(tmo_th), .o_tmo_err(tmo_err));

   int n_chk = 0, n_pass = 0;
   int tbl_a [N];
   int cyc = 0, n_err = 0, policy = 0, ack_dly = 2, att = 0, hold = 0, last_addr = -1, exp_ptr = 0;
   bit req_prev = 1'b0;
   int req_addr_q[$], req_ptr_q[$], req_cyc_q[$], req_flt_q[$], hi_q[$], ack_err_q[$];

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // CRC as remainder of ({1,addr,data} * x^8) mod (x^8+x^2+x+1)
   function automatic logic [7:0] ref_crc(input logic [15:0] d);
      logic [23:0] r;
      r = {d, 8'h00};
      for (int b = 23; b >= 8; b--)
         if (r[b]) r[b -: 9] = r[b -: 9] ^ 9'h107;
      return r[7:0];
   endfunction

   // policy: 0 clean, 1 corrupt first attempt of each entry, 2 corrupt always, 3 never ack
   initial begin
      logic [7:0] data;
      bit bad;
      rac.rd_ack = 1'b0; rac.rd_data = '0; rac.rd_crc = '0;
      forever begin
         @(negedge clk);
         cyc++;
         rac.rd_ack = 1'b0;
         if (rac.rd_req && !req_prev) begin
            req_addr_q.push_back(int'(rac.rd_addr)); req_ptr_q.push_back(int'(scan_ptr));
            req_cyc_q.push_back(cyc); req_flt_q.push_back(int'(scan_fault));
            att = (int'(rac.rd_addr) == last_addr) ? att + 1 : 0;
            last_addr = int'(rac.rd_addr);
            hold = 0;
         end
         if (rac.rd_req) begin
            hold++;
            if (policy != 3 && hold == ack_dly) begin
               data = 8'($urandom);
               bad  = (policy == 2) || (policy == 1 && att == 0);
               rac.rd_data = data;
               rac.rd_crc  = ref_crc({1'b1, rac.rd_addr, data}) ^ (bad ? 8'h5A : 8'h00);
               rac.rd_ack  = 1'b1;
            end
         end else if (req_prev) hi_q.push_back(hold);
         if (crc_err) n_err++;
         if (bist_ack) ack_err_q.push_back(int'(bist_err));
         req_prev = rac.rd_req;
      end
   end

   task automatic wait_reqs(input int n, input int budget);
      int t = 0;
      while (req_addr_q.size() < n && t < budget) begin @(negedge clk); t++; end
      if (req_addr_q.size() < n) chk("req_timeout", req_addr_q.size(), n);
   endtask

   task automatic wait_bist(input int budget);
      int t = 0;
      while (ack_err_q.size() == 0 && t < budget) begin @(negedge clk); t++; end
      chk("bist_ack_seen", ack_err_q.size(), 1);
   endtask

   task automatic clr_logs();
      req_addr_q.delete(); req_ptr_q.delete(); req_cyc_q.delete(); req_flt_q.delete();
      hi_q.delete(); ack_err_q.delete(); n_err = 0; last_addr = -1;
   endtask

   // the entry in flight always completes, so the pointer sits one past the last logged read
   task automatic stop_scan();
      scan_en = 1'b0;
      repeat (80) @(negedge clk);
      if (req_ptr_q.size() > 0) exp_ptr = (req_ptr_q[$] + 1) % N;
      chk("ptr_idle", int'(scan_ptr), exp_ptr);
      clr_logs();
   endtask

   task automatic pulse_clr();
      fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         tbl_a[k] = (k * 37 + 5) % 128;
         tbl_v[k*AW +: AW] = AW'(tbl_a[k]);
      end
      repeat (3) @(negedge clk);
      chk("rst_req", int'(rac.rd_req), 0);   chk("rst_ptr", int'(scan_ptr), 0);
      chk("rst_err", int'(crc_err), 0);      chk("rst_fault", int'(scan_fault), 0);
      chk("rst_back", int'(bist_ack), 0);    chk("rst_tmo", int'(tmo_err), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // clean periodic scan, interval 4, across the pointer wrap
      scan_intv = 4; policy = 0; scan_en = 1'b1;
      wait_reqs(19, 400);
      for (int i = 0; i < 19; i++) begin
         chk("b_addr", req_addr_q[i], tbl_a[(exp_ptr + i) % N]);
         chk("b_ptr", req_ptr_q[i], (exp_ptr + i) % N);
         if (i > 0) chk("b_gap", req_cyc_q[i] - req_cyc_q[i-1], 4 + ack_dly + 1);
      end
      chk("b_err", n_err, 0);
      stop_scan();

      // interval 0 behaves as 1
      scan_intv = 0; scan_en = 1'b1;
      wait_reqs(4, 100);
      for (int i = 1; i < 4; i++) chk("b0_gap", req_cyc_q[i] - req_cyc_q[i-1], 1 + ack_dly + 1);
      stop_scan();

      // first attempt of each entry corrupt: one retry, no failure run
      fail_th = 1; policy = 1; scan_intv = 2; scan_en = 1'b1;
      wait_reqs(8, 200);
      for (int e = 0; e < 4; e++) begin
         chk("c_addr0", req_addr_q[2*e],   tbl_a[(exp_ptr + e) % N]);
         chk("c_addr1", req_addr_q[2*e+1], tbl_a[(exp_ptr + e) % N]);
         chk("c_rgap", req_cyc_q[2*e+1] - req_cyc_q[2*e], ack_dly + 2);
      end
      chk("c_err", n_err, 4);
      chk("c_fault", int'(scan_fault), 0);
      stop_scan();
      chk("c_fault_end", int'(scan_fault), 0);

      // every attempt corrupt, threshold 2
      fail_th = 2; policy = 2; scan_intv = 1; scan_en = 1'b1;
      wait_reqs(7, 300);
      for (int i = 0; i < 7; i++) chk("d_addr", req_addr_q[i], tbl_a[(exp_ptr + i/3) % N]);
      chk("d_err", n_err, 6);
      chk("d_flt1", req_flt_q[3], 0);
      chk("d_flt2", req_flt_q[6], 1);
      pulse_clr();
      chk("d_clr_wins", int'(scan_fault), 0);
      wait_reqs(13, 300);
      chk("d_flt3", req_flt_q[9], 0);
      chk("d_flt4", req_flt_q[12], 1);
      stop_scan();
      pulse_clr();

      // never ack: timeout counts as a miss, threshold 0 keeps fault off
      fail_th = 0; policy = 3; scan_intv = 1; scan_en = 1'b1;
      wait_reqs(4, 300);
      chk("e_hi", hi_q[0], ACK_TMO);
      chk("e_rgap", req_cyc_q[1] - req_cyc_q[0], ACK_TMO + 2);
      for (int i = 0; i < 3; i++) chk("e_addr", req_addr_q[i], tbl_a[exp_ptr]);
      chk("e_addr_nxt", req_addr_q[3], tbl_a[(exp_ptr + 1) % N]);
      chk("e_err", n_err, 3);
      chk("e_fault", int'(scan_fault), 0);
      stop_scan();

      // BIST with scan disabled: clean, then bad CRC on every attempt
      policy = 0; bist_req = 1'b1;
      @(negedge clk);
      chk("f_lat", int'(rac.rd_req), 1);
      wait_bist(60);
      chk("f_nreq", req_addr_q.size(), 1);
      chk("f_addr", req_addr_q[0], tbl_a[exp_ptr]);
      chk("f_berr", ack_err_q[0], 0);
      bist_req = 1'b0; repeat (5) @(negedge clk);
      clr_logs(); policy = 2; bist_req = 1'b1;
      wait_bist(100);
      bist_req = 1'b0;
      chk("f_berr2", ack_err_q[0], 1);
      chk("f_err2", n_err, RETRY_MAX + 1);
      repeat (20) @(negedge clk);
      chk("f_nreq2", req_addr_q.size(), RETRY_MAX + 1);
      for (int i = 0; i < req_addr_q.size(); i++) chk("f_addr2", req_addr_q[i], tbl_a[(exp_ptr + 1) % N]);
      chk("f_ptr", int'(scan_ptr), (exp_ptr + 2) % N);

      // timeout monitors: ch0 unkicked, ch1 kicked every 5 cycles
      tmo_th = {16'd10, 16'd10}; tmo_en = 2'b11;
      for (int k = 1; k <= 13; k++) begin
         tmo_kick[1] = (k % 5 == 0);
         @(negedge clk);
         chk("g_ch0", int'(tmo_err[0]), (k >= 10) ? 1 : 0);
         chk("g_ch1", int'(tmo_err[1]), 0);
      end
      tmo_kick = '0; tmo_en[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("g_dis_sticky", int'(tmo_err[0]), 1);
      tmo_en[0] = 1'b1; tmo_kick[0] = 1'b1;
      @(negedge clk);
      chk("g_kick_clr", int'(tmo_err[0]), 0);
      tmo_kick[0] = 1'b0;
      tmo_th[CW +: CW] = '0; tmo_kick[1] = 1'b1;
      @(negedge clk);
      chk("g_th0_kick", int'(tmo_err[1]), 0);
      tmo_kick[1] = 1'b0;
      @(negedge clk);
      chk("g_th0_set", int'(tmo_err[1]), 1);

      // reset in the middle of a transaction
      clr_logs(); policy = 3; scan_en = 1'b1;
      wait_reqs(1, 50);
      rst_n = 1'b0; #1;
      chk("h_req", int'(rac.rd_req), 0);
      chk("h_ptr", int'(scan_ptr), 0);
      chk("h_tmo", int'(tmo_err), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not reach the summary");
      $fatal(1);
   end
endmodule
